// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle for the bit-serial ALU controller.
// slave is the controller side, master is the requester side.
interface alu_serial_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_illegal;
  logic         busy;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_carry,
    output out_illegal,
    output busy
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_carry,
    input  out_illegal,
    input  busy
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one alu_1bit slice driven LSB-first with a
// registered carry/borrow chain, wrapped in valid/ready handshakes.
module alu_1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       r,
  output logic       cout
);
  logic [1:0] s;

  // SUB: 2-bit two's complement of a-b-cin, msb set when negative
  always_comb begin
    s = 2'b00;
    case (op)
      3'b000:  s = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      3'b001:  s = {1'b0, a} - {1'b0, b} - {1'b0, cin};
      3'b010:  s = {1'b0, a & b};
      3'b011:  s = {1'b0, a | b};
      3'b100:  s = {1'b0, a ^ b};
      default: s = 2'b00;
    endcase
    r    = s[0];
    cout = s[1];
  end
endmodule

module alu_serial_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W)
) (
  input logic               clk,
  input logic               rst,
  alu_serial_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_t           state;
  state_t           state_nx;
  logic [W-1:0]     sh_a;
  logic [W-1:0]     sh_b;
  logic [W-1:0]     res;
  logic [2:0]       op;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             illegal;
  logic             accept;
  logic             finish;
  logic             bit_r;
  logic             bit_c;

  assign accept = bus.in_valid & (state == IDLE);
  assign finish = bus.out_ready & (state == DONE);

  alu_1bit u_slice (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .op   (op),
    .r    (bit_r),
    .cout (bit_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a    <= '0;
      sh_b    <= '0;
      res     <= '0;
      op      <= 3'b000;
      cnt     <= '0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      sh_a    <= bus.in_a;
      sh_b    <= bus.in_b;
      op      <= bus.in_op;
      cnt     <= '0;
      carry   <= 1'b0;
      illegal <= bus.in_op > 3'b100;
    end else if (state == RUN) begin
      // result fills from the top so bit 0 lands at the LSB after W shifts
      res   <= {bit_r, res[W-1:1]};
      carry <= bit_c;
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state == RUN) | (state == DONE);
  assign bus.out_result  = res;
  assign bus.out_carry   = carry;
  assign bus.out_illegal = illegal;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed and random checks of alu_serial_ctrl against an
// arithmetic reference model.
module tb_alu_serial_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_serial_ctrl_if #(.W(W)) bus ();

  alu_serial_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // returns {illegal, carry, result}
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [2:0] op);
    int unsigned ua;
    int unsigned ub;
    int unsigned r;
    logic c;
    ua = a;
    ub = b;
    r  = 0;
    c  = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; c = (r >= (1 << W)); end
      3'd1: begin r = ua - ub; c = (ua < ub); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      default: r = 0;
    endcase
    return {op > 3'd4, c, r[W-1:0]};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int hold);
    logic [W+1:0] e;
    int n;
    e = ref_model(a, b, op);
    chk("pre_ready", 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_op    = 3'($urandom);
    chk("busy_run", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    chk("result", 32'(bus.out_result), 32'(e[W-1:0]));
    chk("carry", 32'(bus.out_carry), 32'(e[W]));
    chk("illegal", 32'(bus.out_illegal), 32'(e[W+1]));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_result", 32'(bus.out_result), 32'(e[W-1:0]));
      chk("hold_carry", 32'(bus.out_carry), 32'(e[W]));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_ready", 32'(bus.in_ready), 32'd1);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_result", 32'(bus.out_result), 32'(e[W-1:0]));
  endtask

  initial begin
    logic seen_valid;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 3'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.out_result), 32'd0);
    chk("rst_carry", 32'(bus.out_carry), 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'hFF, 8'h01, 3'd0, 0);
    run_op(8'h05, 8'h07, 3'd1, 0);
    run_op(8'h07, 8'h05, 3'd1, 0);
    run_op(8'hCA, 8'h5C, 3'd2, 0);
    run_op(8'hCA, 8'h5C, 3'd3, 0);
    run_op(8'hCA, 8'h5C, 3'd4, 0);
    run_op(8'h33, 8'h44, 3'd0, 5);
    run_op(8'h80, 8'h80, 3'd0, 0);
    run_op(8'hFF, 8'hFF, 3'd7, 0);

    bus.in_a     = 8'h7F;
    bus.in_b     = 8'h01;
    bus.in_op    = 3'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_result", 32'(bus.out_result), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | bus.out_valid;
    end
    chk("mrst_novalid", 32'(seen_valid), 32'd0);
    run_op(8'h10, 8'h20, 3'd0, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
